// File: rtl/regfile_scb.sv
// Parameterised register file with a per-register busy scoreboard.
// After reset every register is zeroed, one per clock, before ready rises.
module regfile_scb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rv,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     wdata,
  input  logic                alloc,
  input  logic [AW-1:0]       alloc_rd,
  output logic                ready
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en, alloc_en;

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR: if (cnt == LAST) state_nx = READY;
      READY: state_nx = READY;
    endcase
  end

  always_comb begin
    ready = (state == READY);
  end

  always_ff @(posedge clk) begin
    if (reset)                              cnt <= '0;
    else if (state == CLEAR && cnt != LAST) cnt <= cnt + AW'(1);
  end

  // Register 0 is hardwired when ZERO_REG is set, so it never takes data or a producer.
  assign wr_en    = ready && we    && !(ZERO_REG != 0 && rd == '0);
  assign alloc_en = ready && alloc && !(ZERO_REG != 0 && alloc_rd == '0);

  // Storage is left untouched in a reset cycle; the clear sweep zeroes it afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_en)     mem[rd]  <= wdata;
    end
  end

  // A new producer allocated in the same cycle as a write-back to that register wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_en)    busy[rd]       <= 1'b0;
      if (alloc_en) busy[alloc_rd] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          fwd;
    assign addr    = rs[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign fwd     = (BYPASS != 0) && wr_en && (rd == addr);
    assign rv[k*XLEN +: XLEN] = (!ready || is_zero) ? '0 :
                                fwd                 ? wdata : mem[addr];
    assign rbusy[k] = ready && busy[addr];
  end

endmodule

// File: doc/regfile_scb.md
REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 Parameter XLEN, default 32: register width in bits.
REQ-002 Parameter NREG, default 32: number of registers, a power of two ≥ 4; localparam AW = log2(NREG).
REQ-003 Parameter NRD, default 2: number of combinational read ports, 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write data forwarded to read ports.
REQ-005 Parameter ZERO_REG, default 1: 1 = register 0 reads 0 and ignores writes/allocs.
REQ-006 Port clk  input  1: single clock, all state changes at posedge.
REQ-007 Port reset  input  1: synchronous active-high reset, sampled at posedge clk.
REQ-008 Port rs  input  NRD*AW: read addresses, port k at bits [k*AW +: AW].
REQ-009 Port rv  output  NRD*XLEN: read data, port k at bits [k*XLEN +: XLEN].
REQ-010 Port rbusy  output  NRD: bit k = scoreboard busy bit of rs port k.
REQ-011 Port we  input  1: write enable.
REQ-012 Port rd  input  AW: write address.
REQ-013 Port wdata  input  XLEN: write data.
REQ-014 Port alloc  input  1: mark alloc_rd as pending (producer issued).
REQ-015 Port alloc_rd  input  AW: register being allocated.
REQ-016 Port ready  output  1: high when clear sequence is done and the file is usable.

Function
REQ-017 Two-state FSM: CLEAR, READY; state and clear counter cnt (AW bits) are the only control state.
REQ-018 CLEAR: each posedge with reset=0 writes mem[cnt]=0; if cnt==NREG-1 go to READY, else cnt=cnt+1.
REQ-019 ready = 1 only in READY; ready is combinational from state.
REQ-020 While ready=0: rv all zero, rbusy all zero, we and alloc ignored.
REQ-021 READY write: at posedge with we=1, mem[rd]=wdata, except rd==0 with ZERO_REG=1 (no change).
REQ-022 Read: rv port k = mem[rs_k], combinational; rs_k==0 with ZERO_REG=1 yields 0.
REQ-023 BYPASS=1: if we=1 and rd==rs_k (and not the zero register), rv port k = wdata in the same cycle; BYPASS=0: old contents until next edge.
REQ-024 Scoreboard: NREG busy bits; at posedge in READY, alloc=1 sets busy[alloc_rd]; we=1 clears busy[rd].
REQ-025 Simultaneous alloc and we to the same register: busy ends set (new producer wins); wdata is still written.
REQ-026 Simultaneous alloc and we to different registers: both take effect.
REQ-027 alloc to register 0 with ZERO_REG=1: ignored; busy[0] is always 0.
REQ-028 rbusy port k = busy[rs_k], combinational; no bypass of same-cycle alloc or write on rbusy.
REQ-029 Write to a non-busy register is legal; the data is written and busy stays 0.
REQ-030 All read ports are independent; duplicate addresses on multiple ports return identical data.

Reset
REQ-031 Posedge with reset=1: state=CLEAR, cnt=0, all busy bits=0; mem contents are not required to change in that cycle.
REQ-032 Reset output values: ready=0, rv=0, rbusy=0, held until READY.
REQ-033 ready rises after exactly NREG posedges with reset=0 following the last reset cycle.
REQ-034 Reset during CLEAR restarts at cnt=0; reset during READY discards all pending writes and allocs in that cycle.
REQ-035 No dependence on initial blocks; behaviour after the first reset is fully defined.

Verification
REQ-036 Reset 1 cycle, then release (NREG=32) -> ready=0 for 31 edges, 1 after the 32nd edge; every register reads 0.
REQ-037 READY, we=1 rd=5 wdata=0xDEADBEEF, rs0=5 same cycle -> rv0=0xDEADBEEF (BYPASS=1); with BYPASS=0, rv0=0 until next edge, then 0xDEADBEEF.
REQ-038 we=1 rd=0 wdata=0x1234, alloc=1 alloc_rd=0 -> rv for rs=0 stays 0, rbusy=0.
REQ-039 alloc rd=7; next cycle rs1=7 -> rbusy1=1; we rd=7 wdata=0x55 -> after edge rbusy1=0, rv1=0x55.
REQ-040 Same cycle alloc rd=9 and we rd=9 wdata=0xA -> after edge busy[9]=1, mem[9]=0xA.
REQ-041 Reset asserted at cnt=10 of CLEAR, released -> full 32-cycle clear again; we/alloc during CLEAR have no effect after READY.
